readout_arbiter: RTL and testbench

- Grants the single serial readout path to one of three requesters at a time: timestamp, bank 0 and bank 1.
- Sits between the acquisition memory controller (bank-full flags, memorization complete) and the serial readout sequencer.
- Adds the following on top of the grant logic:
  - a fixed ordering rule: the timestamp is sent before bank data;
  - round-robin between the two banks;
  - a post-transfer holdoff;
  - a watchdog that revokes hung grants and counts dropped transfers.

---
 rtl/readout_pkg.sv | 34 +++
 rtl/arb_timer.sv | 30 +++
 rtl/readout_arbiter.sv | 140 ++++++++++++++
 tb/tb_readout_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared types and constants for the readout arbiter.
//   state_t      : arbiter FSM states (IDLE, GRANT, HOLDOFF)
//   REQ_*        : requester bit positions in req/done/grant
//   pick_winner  : fixed-priority / round-robin winner selection
package readout_pkg;

  localparam int N_REQ  = 3;
  localparam int REQ_TS = 0;
  localparam int REQ_B0 = 1;
  localparam int REQ_B1 = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  // Timestamp always wins; when both banks request, rr_ptr picks
  // (0 = bank0 preferred, 1 = bank1 preferred).
  function automatic logic [N_REQ-1:0] pick_winner(input logic [N_REQ-1:0] req,
                                                   input logic             rr_ptr);
    logic [N_REQ-1:0] w;
    w = '0;
    if (req[REQ_TS])                    w[REQ_TS] = 1'b1;
    else if (req[REQ_B0] && req[REQ_B1]) begin
      if (rr_ptr) w[REQ_B1] = 1'b1;
      else        w[REQ_B0] = 1'b1;
    end
    else if (req[REQ_B0])               w[REQ_B0] = 1'b1;
    else if (req[REQ_B1])               w[REQ_B1] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/arb_timer.sv
// Loadable up-counter with clear and terminal compare, shared by the
// watchdog and holdoff functions of the readout arbiter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : force count to 0 (highest priority after reset)
//   load       : load count from load_val
//   en         : count up by one
//   term       : terminal value; at_term is high while count == term
module arb_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (load)      count <= load_val;
    else if (en)        count <= count + 1'b1;
  end

  assign at_term = (count == term);

endmodule

// File: rtl/readout_arbiter.sv
// Grants the serial readout path to one of timestamp / bank0 / bank1.
// Timestamp has absolute priority, the banks alternate round-robin, each
// completed transfer is followed by a holdoff, and a watchdog revokes
// grants that never see their done pulse.
//   clk, reset    : readout clock, synchronous active-high reset
//   req[2:0]      : level requests {bank1, bank0, timestamp}
//   done[2:0]     : one-cycle completion pulses from the sequencer
//   grant[2:0]    : registered one-hot grant (or zero)
//   busy          : high in GRANT or HOLDOFF
//   timeout_flag  : sticky watchdog indication
//   drop_count    : saturating count of revoked/aborted grants
//   grant_total   : saturating count of completed transfers
// Build option: define ARB_STATS_EN to implement grant_total; otherwise
// it is tied to zero.
module readout_arbiter
  import readout_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int DROP_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      done,
  output logic [N_REQ-1:0]      grant,
  output logic                  busy,
  output logic                  timeout_flag,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic [15:0]           grant_total
);

  localparam int TMAX = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] TO_TERM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] HO_TERM = TW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
  // With no holdoff configured, leave GRANT straight to IDLE.
  localparam state_t POST_XFER = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;

  state_t           state, state_n;
  logic [N_REQ-1:0] grant_n;
  logic             rr_ptr, rr_n;
  logic             tflag_n, drop_inc, total_inc;
  logic             done_g, req_g;
  logic [TW-1:0]    tcount, tterm;
  logic             at_term, tclear;

  assign done_g = |(done & grant);
  assign req_g  = |(req & grant);
  assign tterm  = (state == GRANT) ? TO_TERM : HO_TERM;
  // Timer restarts from 0 on every state entry.
  assign tclear = (state_n != state);

  arb_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tclear),
    .load     (1'b0),
    .load_val ('0),
    .en       (state != IDLE),
    .term     (tterm),
    .count    (tcount),
    .at_term  (at_term)
  );

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    rr_n      = rr_ptr;
    tflag_n   = timeout_flag;
    drop_inc  = 1'b0;
    total_inc = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_n = pick_winner(req, rr_ptr);
          state_n = GRANT;
        end
      end
      GRANT: begin
        // done beats both a simultaneous req drop and the watchdog
        if (done_g) begin
          grant_n   = '0;
          total_inc = 1'b1;
          if (!grant[REQ_TS]) rr_n = grant[REQ_B0];
          state_n   = POST_XFER;
        end else if (!req_g) begin
          grant_n  = '0;
          drop_inc = 1'b1;
          state_n  = IDLE;
        end else if (at_term) begin
          grant_n  = '0;
          tflag_n  = 1'b1;
          drop_inc = 1'b1;
          if (!grant[REQ_TS]) rr_n = grant[REQ_B0];
          state_n  = POST_XFER;
        end
      end
      HOLDOFF: begin
        grant_n = '0;
        if (at_term) state_n = IDLE;
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      busy         <= 1'b0;
      rr_ptr       <= 1'b0;
      timeout_flag <= 1'b0;
      drop_count   <= '0;
    end else begin
      state        <= state_n;
      grant        <= grant_n;
      busy         <= (state_n != IDLE);
      rr_ptr       <= rr_n;
      timeout_flag <= tflag_n;
      if (drop_inc && (drop_count != {DROP_CNT_W{1'b1}}))
        drop_count <= drop_count + 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)                                   grant_total <= '0;
    else if (total_inc && (grant_total != 16'hFFFF)) grant_total <= grant_total + 16'd1;
  end
`else
  assign grant_total = 16'd0;
  logic unused_total;
  assign unused_total = total_inc;
`endif

endmodule

// File: tb/tb_readout_arbiter.sv
// Scoreboard bench for readout_arbiter (HOLDOFF=16, TIMEOUT=8, DROP_CNT_W=2).
// Stimulus pushes each expected output change (with the cycle it must
// happen on); the monitor pops one entry every time the output tuple
// changes and compares value and cycle.
module tb_readout_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, done;
  logic [2:0]  grant;
  logic        busy, timeout_flag;
  logic [1:0]  drop_count;
  logic [15:0] grant_total;

  readout_arbiter #(
    .HOLDOFF_CYCLES (16),
    .TIMEOUT_CYCLES (8),
    .DROP_CNT_W     (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .done         (done),
    .grant        (grant),
    .busy         (busy),
    .timeout_flag (timeout_flag),
    .drop_count   (drop_count),
    .grant_total  (grant_total)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    int          at;
    logic [22:0] v;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0, n_pass = 0;
  logic        mon_en = 1'b0;
  logic        exp_tf = 1'b0;
  logic [1:0]  exp_dc = 2'd0;
  logic [15:0] exp_gt = 16'd0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic ex(input string nm, input int at, input logic [2:0] g, input logic b);
    exp_t e;
    e.nm = nm;
    e.at = at;
    e.v  = {g, b, exp_tf, exp_dc, exp_gt};
    exp_q.push_back(e);
  endtask

  // Pulse done on the granted bit so it lands d cycles after grant g,
  // changing req to ra in the same cycle; expects the 16-cycle holdoff.
  task automatic complete(input string nm, input int g, input logic [2:0] gb,
                          input int d, input logic [2:0] ra);
    wait_until(g + d - 1);
    done = gb;
    req  = ra;
`ifdef ARB_STATS_EN
    exp_gt = exp_gt + 16'd1;
`endif
    ex({nm, "_done"}, g + d, 3'b000, 1'b1);
    ex({nm, "_idle"}, g + d + 16, 3'b000, 1'b0);
    tick(1);
    done = 3'b000;
  endtask

  // Monitor: one scoreboard pop per output change.
  logic [22:0] prev;
  logic        first = 1'b1;
  always @(negedge clk) begin
    logic [22:0] cur;
    exp_t        e;
    if (mon_en) begin
      cur = {grant, busy, timeout_flag, drop_count, grant_total};
      if (first || cur !== prev) begin
        first = 1'b0;
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change cyc=%0d got g=%b b=%b tf=%b dc=%0d gt=%0d, want no change",
                   cyc, cur[22:20], cur[19], cur[18], cur[17:16], cur[15:0]);
        end else begin
          e = exp_q.pop_front();
          if (e.v !== cur || e.at != cyc)
            $display("FAIL %s got g=%b b=%b tf=%b dc=%0d gt=%0d @%0d, want g=%b b=%b tf=%b dc=%0d gt=%0d @%0d",
                     e.nm, cur[22:20], cur[19], cur[18], cur[17:16], cur[15:0], cyc,
                     e.v[22:20], e.v[19], e.v[18], e.v[17:16], e.v[15:0], e.at);
          else
            n_pass++;
        end
      end
      prev = cur;
    end
  end

  initial begin
    int g;
    reset = 1'b1;
    req   = 3'b000;
    done  = 3'b000;
    tick(2);
    reset = 1'b0;
    ex("reset", 2, 3'b000, 1'b0);
    mon_en = 1'b1;

    // 1: timestamp alone, done 5 cycles after grant
    req = 3'b001;
    ex("t1_grant", 3, 3'b001, 1'b1);
    complete("t1", 3, 3'b001, 5, 3'b000);

    // 2: both banks, alternating
    wait_until(25);
    req = 3'b110;
    ex("t2_g0", 26, 3'b010, 1'b1);
    complete("t2a", 26, 3'b010, 3, 3'b110);
    ex("t2_g1", 46, 3'b100, 1'b1);
    complete("t2b", 46, 3'b100, 3, 3'b110);
    ex("t2_g2", 66, 3'b010, 1'b1);
    complete("t2c", 66, 3'b010, 3, 3'b000);

    // 3: all three: timestamp first, then bank1 (rr_ptr after bank0 done)
    wait_until(86);
    req = 3'b111;
    ex("t3_ts", 87, 3'b001, 1'b1);
    complete("t3a", 87, 3'b001, 2, 3'b110);
    ex("t3_b1", 106, 3'b100, 1'b1);
    complete("t3b", 106, 3'b100, 2, 3'b010);

    // 4: bank0 held with no done -> watchdog after 8 cycles
    ex("t4_grant", 125, 3'b010, 1'b1);
    exp_tf = 1'b1;
    exp_dc = 2'd1;
    ex("t4_revoke", 133, 3'b000, 1'b1);
    ex("t4_idle", 149, 3'b000, 1'b0);
    wait_until(140);
    req = 3'b110;
    ex("t4_next_b1", 150, 3'b100, 1'b1);
    complete("t4c", 150, 3'b100, 3, 3'b010);

    // 5: stray done on non-granted bit, then abort with no holdoff
    ex("t5_grant", 170, 3'b010, 1'b1);
    wait_until(170);
    done = 3'b100;
    tick(1);
    done = 3'b000;
    wait_until(172);
    req = 3'b000;
    exp_dc = 2'd2;
    ex("t5_abort", 173, 3'b000, 1'b0);
    wait_until(173);
    req = 3'b100;
    ex("t5_regrant", 174, 3'b100, 1'b1);
    complete("t5", 174, 3'b100, 2, 3'b000);

    // 6: five timeouts saturate the 2-bit drop counter at 3
    wait_until(193);
    req = 3'b010;
    g = 194;
    for (int i = 0; i < 5; i++) begin
      ex($sformatf("t6_grant%0d", i), g, 3'b010, 1'b1);
      if (exp_dc != 2'd3) exp_dc = exp_dc + 2'd1;
      ex($sformatf("t6_revoke%0d", i), g + 8, 3'b000, 1'b1);
      ex($sformatf("t6_idle%0d", i), g + 24, 3'b000, 1'b0);
      g = g + 25;
    end
    ex("t6_grant5", g, 3'b010, 1'b1);

    // reset mid-GRANT clears everything on the next edge
    wait_until(321);
    reset = 1'b1;
    exp_tf = 1'b0;
    exp_dc = 2'd0;
    exp_gt = 16'd0;
    ex("t6_reset", 322, 3'b000, 1'b0);
    wait_until(322);
    reset = 1'b0;
    ex("t6_post_reset", 323, 3'b010, 1'b1);
    wait_until(323);
    req = 3'b000;
    exp_dc = 2'd1;
    ex("t6_abort", 324, 3'b000, 1'b0);

    wait_until(335);
    mon_en = 1'b0;
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      $display("FAIL %s never_seen got no change, want change @%0d", e.nm, e.at);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
